// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder in front of a
// 16-bit word array, with request/response valid-ready handshakes.
// Optional access wait states are enabled by defining the macro DMEM_WAIT_EN;
// without it, the WAIT state and its counter are not built.
module dmem_responder #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    // Reject illegal parameter combinations at elaboration time
    generate
        if (DEPTH < 2 || DEPTH > 1024 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_param_check
            $error("dmem_responder: DEPTH or WAIT_CYCLES out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef DMEM_WAIT_EN
        S_WAIT,
`endif
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic   err_q, err_d;        // response is an out-of-range error
    logic   ld_ok_q, ld_ok_d;    // response carries valid load data
    logic   commit;              // this edge enters RESP and touches the array

    logic [15:0] mem_array [DEPTH];
    logic [15:0] mem_rdata_q;

    // Fields of the access being committed this cycle
    logic          cm_we;
    logic [15:0]   cm_addr;
    logic [15:0]   cm_wdata;
    logic          cm_in_range;
    logic [AW-1:0] cm_idx;

`ifdef DMEM_WAIT_EN
    localparam int EFF_WAIT = WAIT_CYCLES;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
`endif

    // Select commit source: live request from IDLE, latched request from WAIT
    always_comb begin
        cm_we    = req_we;
        cm_addr  = req_addr;
        cm_wdata = req_wdata;
`ifdef DMEM_WAIT_EN
        if (state_q != S_IDLE) begin
            cm_we    = we_q;
            cm_addr  = addr_q;
            cm_wdata = wdata_q;
        end
`endif
    end

    // Full 16-bit compare: high address bits never alias into the array
    assign cm_in_range = ({1'b0, cm_addr} < DEPTH_W);
    assign cm_idx      = cm_addr[AW-1:0];

    // Next-state, counter and response-flag logic
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ld_ok_d = ld_ok_q;
        commit  = 1'b0;
`ifdef DMEM_WAIT_EN
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
`ifdef DMEM_WAIT_EN
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (EFF_WAIT == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(EFF_WAIT);
                    end
`else
                    state_d = S_RESP;
                    commit  = 1'b1;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            S_WAIT: begin
                // Counter hits zero on the same edge that enters RESP
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = !cm_in_range;
            ld_ok_d = cm_in_range && !cm_we;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            ld_ok_q <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ld_ok_q <= ld_ok_d;
`ifdef DMEM_WAIT_EN
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`endif
        end
    end

    // Array write at commit; reset wins so an in-flight store is dropped
    always_ff @(posedge clk) begin
        if (commit && !rst && cm_in_range && cm_we) begin
            mem_array[cm_idx] <= cm_wdata;
        end
    end

    // Registered array read at commit; held through RESP since nothing else writes
    always_ff @(posedge clk) begin
        if (commit && !rst && cm_in_range && !cm_we) begin
            mem_rdata_q <= mem_array[cm_idx];
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && ld_ok_q) ? mem_rdata_q : 16'd0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of 16-bit data words; legal range 2..1024.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the added access wait states (used only with DMEM_WAIT_EN); legal range 0..15.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store (SW), 0 = load (LW).
REQ-008 req_addr  input  16  word address (base register + immediate, already summed by the initiator).
REQ-009 req_wdata  input  16  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts the response.
REQ-012 rsp_rdata  output  16  load data; 0 for stores and errored accesses.
REQ-013 rsp_err  output  1  address was out of range (req_addr >= DEPTH).

Function
REQ-014 The block SHALL implement the states IDLE, WAIT and RESP, with one transaction outstanding at most.
REQ-015 In IDLE, req_ready SHALL be 1; in WAIT and RESP, it SHALL be 0.
REQ-016 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; req_we, req_addr and req_wdata SHALL be latched at that edge.
REQ-017 Requests SHALL leave IDLE as follows: with effective wait count 0, go to RESP; otherwise go to WAIT, with the counter loaded to the wait count.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 0, so that rsp_valid rises exactly (wait count + 1) cycles after acceptance.
REQ-019 The commit point SHALL be the edge entering RESP: a store writes the array and a load captures the array word into rsp_rdata.
REQ-020 Out-of-range addresses SHALL be handled at the commit point: the array is not accessed, rsp_err=1 and rsp_rdata=0; for stores, the array is unmodified.
REQ-021 The range check SHALL use all 16 address bits, with no wrap-around or truncation modulo DEPTH.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1.
REQ-023 A response handshake (rsp_valid & rsp_ready) SHALL return the block to IDLE, with rsp_valid=0 and req_ready=1 on the next cycle.
REQ-024 A new request SHALL NOT be accepted in the same cycle as the response handshake, so minimum occupancy is (wait count + 2) cycles per transaction.
REQ-025 Request inputs SHALL be ignored outside IDLE.
REQ-026 A load following a store to the same address SHALL return the stored value.
REQ-027 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-028 When rst=1 at an edge, the block SHALL enter IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0, regardless of state.
REQ-029 Reset during WAIT SHALL discard the transaction; a pending store SHALL NOT be written.
REQ-030 Reset during RESP SHALL drop the response; an already-committed store SHALL remain written.
REQ-031 Array contents SHALL NOT be affected by reset.
REQ-032 req_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-033 With macro DMEM_WAIT_EN defined, the effective wait count SHALL be WAIT_CYCLES, giving a load/store latency of WAIT_CYCLES+1 cycles.
REQ-034 Without DMEM_WAIT_EN, the effective wait count SHALL be 0; the WAIT state and counter SHALL be compiled out, and rsp_valid SHALL rise 1 cycle after acceptance.

Verification
REQ-035 Store then load: store addr 3, data 0x1234, then load addr 3 -> response 0x1234 with rsp_err=0; with DMEM_WAIT_EN and WAIT_CYCLES=2, rsp_valid rises 3 cycles after each acceptance, and without the macro, 1 cycle after.
REQ-036 Out of range: store addr 16 with DEPTH=16 and data 0xBEEF -> rsp_err=1 and rsp_rdata=0; a following load of addr 0 returns its prior value; load addr 0xFFFF -> rsp_err=1 and rsp_rdata=0.
REQ-037 Backpressure: load addr 5 with rsp_ready=0 held for 4 cycles -> rsp_valid and rsp_rdata remain stable and req_ready=0 throughout; a req_valid pulse during this time is ignored.
REQ-038 Reset mid-WAIT (DMEM_WAIT_EN): store addr 7 with 0xAAAA, then rst one cycle after acceptance -> outputs return to reset values; a later load of addr 7 returns the old value, not 0xAAAA.
REQ-039 Back-to-back: req_valid held high for 3 loads with rsp_ready=1 -> exactly 3 responses, each separated by at least (wait count + 2) cycles between acceptances, with data in request order.
